// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;

  // Control payload field layout (LSB offset / width).
  localparam int unsigned ALU_OP_LSB = 0;
  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned RAM_WE_LSB = 5;
  localparam int unsigned RAM_WE_W   = 1;
  localparam int unsigned RF_WE_LSB  = 6;
  localparam int unsigned RF_WE_W    = 1;
  localparam int unsigned NPC_OP_LSB = 7;
  localparam int unsigned NPC_OP_W   = 3;
  localparam int unsigned FLAG_LSB   = 10;
  localparam int unsigned FLAG_W     = 1;

  // Per-stage control widths.
  localparam int unsigned CTRL_W_IF_ID  = 24;
  localparam int unsigned CTRL_W_ID_EX  = 24;
  localparam int unsigned CTRL_W_EX_MEM = 24;
  localparam int unsigned CTRL_W_MEM_WB = 24;

  // Default kill masks: bits that must read zero on a bubble so it has no side effects.
  localparam logic [23:0] KILL_ID_EX  = (24'(1) << RAM_WE_LSB) | (24'(1) << RF_WE_LSB)
                                      | (24'(7) << NPC_OP_LSB) | (24'(1) << FLAG_LSB);
  localparam logic [23:0] KILL_EX_MEM = (24'(1) << RAM_WE_LSB) | (24'(1) << RF_WE_LSB)
                                      | (24'(1) << FLAG_LSB);
  localparam logic [23:0] KILL_MEM_WB = (24'(1) << RF_WE_LSB);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus datapath and control payload registers.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = CTRL_W_ID_EX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_kill,
  input  logic [CTRL_W-1:0] i_kill_mask,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Kill beats load beats clear; kill keeps data but scrubs masked control bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_kill) begin
      r_valid <= 1'b0;
      r_ctrl  <= r_ctrl & ~i_kill_mask;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid and stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      DATA_W         = 64,
  parameter int unsigned      CTRL_W         = CTRL_W_ID_EX,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = '0,
  parameter int unsigned      STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;

  logic              w_acc;
  logic              w_pop;
  logic              w_main_load;
  logic              w_main_clear;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CTRL_W-1:0] w_main_ctrl_in;

  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Handshake and steering: main refills from skid first to preserve order.
  always_comb begin
    w_acc          = in_valid & ~w_skid_valid;
    w_pop          = w_main_valid & out_ready;
    w_main_load    = (~w_main_valid | w_pop) & (w_skid_valid | w_acc);
    w_main_clear   = w_pop & ~w_skid_valid & ~w_acc;
    w_skid_load    = w_main_valid & ~w_pop & w_acc;
    w_skid_clear   = w_pop & w_skid_valid;
    w_main_data_in = w_skid_valid ? w_skid_data : in_data;
    w_main_ctrl_in = w_skid_valid ? w_skid_ctrl : in_ctrl;
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_main_load),
    .i_clear     (w_main_clear),
    .i_kill      (flush),
    .i_kill_mask (CTRL_KILL_MASK),
    .i_data      (w_main_data_in),
    .i_ctrl      (w_main_ctrl_in),
    .o_valid     (w_main_valid),
    .o_data      (w_main_data),
    .o_ctrl      (w_main_ctrl)
  );

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_skid_load),
    .i_clear     (w_skid_clear),
    .i_kill      (flush),
    .i_kill_mask (CTRL_KILL_MASK),
    .i_data      (in_data),
    .i_ctrl      (in_ctrl),
    .o_valid     (w_skid_valid),
    .o_data      (w_skid_data),
    .o_ctrl      (w_skid_ctrl)
  );

  // Saturating count of cycles where the downstream stage back-pressures a live entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid & ~out_ready & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign in_ready  = ~w_skid_valid;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign out_ctrl  = w_main_ctrl & (w_main_valid ? {CTRL_W{1'b1}} : ~CTRL_KILL_MASK);
  assign occupancy = 2'(w_main_valid) + 2'(w_skid_valid);
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model plus directed literal checks.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 24;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] MASK = 24'h00000F;
  localparam int CNT_MAX = (1 << SW) - 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .CTRL_KILL_MASK(MASK), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of at most two live entries, plus the last
  // payload seen at the head (the stage keeps it after the entry leaves).
  ent_t          q[$];
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;
  bit            live = 1'b0;

  always @(posedge clk) begin : model
    int sz;
    bit acc, pop;
    sz  = q.size();
    acc = in_valid && (sz < 2);
    pop = (sz > 0) && out_ready;
    if (rst) begin
      q.delete();
      m_data = '0;
      m_ctrl = '0;
      m_cnt  = 0;
      live   = 1'b1;
    end else if (live) begin
      if ((sz > 0) && !out_ready && (m_cnt < CNT_MAX)) m_cnt++;
      if (flush) begin
        q.delete();
        m_ctrl = m_ctrl & ~MASK;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back('{in_data, in_ctrl});
        if (q.size() > 0) begin
          m_data = q[0].d;
          m_ctrl = q[0].c;
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      chk("out_ctrl", 64'(out_ctrl), 64'((q.size() > 0) ? m_ctrl : (m_ctrl & ~MASK)));
      if (q.size() > 0) chk("out_data", out_data, m_data);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [47:0] pat_v;
    logic [47:0] pat_r;
    pat_v = 48'hF3A5_96C3_B7E1;
    pat_r = 48'h5C96_1DB3_E4A7;

    // 1: reset wins over an offered entry
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'd5; in_ctrl = 24'h0; out_ready = 1'b0;
    step();
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    chk("t1_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("t1_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    step();

    // 2: streaming at full rate
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 64'(i); in_ctrl = 24'(i);
      step();
      chk("t2_out_data", out_data, 64'(i));
      chk("t2_occupancy", 64'(occupancy), 64'd1);
      chk("t2_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("t2_drained", 64'(out_valid), 64'd0);

    // 3: back-pressure fills the skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd1;
    step();
    in_data = 64'd2;
    step();
    in_valid = 1'b0;
    step();
    chk("t3_occupancy", 64'(occupancy), 64'd2);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_held", out_data, 64'd1);
    out_ready = 1'b1;
    step();
    chk("t3_second", out_data, 64'd2);
    chk("t3_occ1", 64'(occupancy), 64'd1);
    step();
    chk("t3_empty", 64'(occupancy), 64'd0);

    // 4: flush of a full stage scrubs killed ctrl bits
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 24'hFFFFFF; in_data = 64'd1;
    step();
    in_data = 64'd2;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_occupancy", 64'(occupancy), 64'd0);
    chk("t4_out_ctrl", 64'(out_ctrl), 64'h00FFFFF0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);

    // 5: accept in a flush cycle is dropped; reset beats flush
    in_valid = 1'b1; in_data = 64'd7; in_ctrl = 24'h000123;
    step();
    chk("t5_loaded", out_data, 64'd7);
    flush = 1'b1; in_data = 64'd8;
    step();
    chk("t5_drop_full", 64'(out_valid), 64'd0);
    step();
    chk("t5_drop_empty", 64'(out_valid), 64'd0);
    rst = 1'b1;
    step();
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_ready", 64'(in_ready), 64'd1);
    chk("t5_rst_ctrl", 64'(out_ctrl), 64'd0);
    chk("t5_rst_data", out_data, 64'd0);
    chk("t5_rst_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

    // 6: stall counter saturates and only reset clears it
    in_valid = 1'b1; in_data = 64'd9; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("t6_saturated", 64'(stall_cnt), 64'd15);
    chk("t6_held", out_data, 64'd9);
    rst = 1'b1;
    step();
    chk("t6_rst_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Mixed traffic: fixed valid/ready patterns with periodic flushes
    for (int i = 0; i < 48; i++) begin
      in_valid  = pat_v[i];
      out_ready = pat_r[i];
      flush     = ((i % 17) == 16);
      in_data   = 64'(100 + i);
      in_ctrl   = 24'((i * 37) ^ 24'hA5A5A5);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("mix_drained", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
